// File: rtl/memory_arbiter_defs.sv
// Shared encodings for the memory write-stream arbiter.
package memory_arbiter_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT01 = 2'd1,
    ST_GRANT02 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S01  = 2'b01;
  localparam logic [1:0] GRANT_S02  = 2'b10;

  // Identifies which requester finished the most recent packet.
  localparam logic OWNER_S01 = 1'b0;
  localparam logic OWNER_S02 = 1'b1;

endpackage

// File: rtl/axis_output_register.sv
// One-entry AXI-Stream register slice: holds tdata/tstrb/tlast and tvalid.
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high; once valid is raised, the payload stays stable until
// that edge. in_ready = !out_valid || out_ready, so a load and a drain can
// happen on the same edge and the slice sustains one beat per cycle.
module axis_output_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_strb,
  output logic                    out_last
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat when space is available; otherwise drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_strb  <= in_strb;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_stream_arbiter.sv
// Packet-granular two-requester round-robin arbiter in front of the memory
// write stream. A grant lasts until the owner's tlast beat is accepted; one
// IDLE cycle separates packets, and completed packets are counted per source.
module memory_stream_arbiter
  import memory_arbiter_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s02_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
  input  logic                    s02_axis_tvalid,
  input  logic                    s02_axis_tlast,
  output logic                    s02_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    pkt_cnt01,
  output logic [CNT_WIDTH-1:0]    pkt_cnt02,
  output logic [1:0]              dbg_state
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  arb_state_e state;
  logic       last_owner;
  logic       slot_ready;
  logic       acc01;
  logic       acc02;
  logic       load_valid;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [DATA_WIDTH/8-1:0] load_strb;
  logic                    load_last;

  assign dbg_state = state;

  // Only the owner sees the output slot's readiness; the other side waits.
  assign s01_axis_tready = (state == ST_GRANT01) && slot_ready;
  assign s02_axis_tready = (state == ST_GRANT02) && slot_ready;

  assign acc01      = s01_axis_tvalid && s01_axis_tready;
  assign acc02      = s02_axis_tvalid && s02_axis_tready;
  assign load_valid = acc01 || acc02;

  // Steer the owner's payload into the output slice.
  always_comb begin
    load_data = s01_axis_tdata;
    load_strb = s01_axis_tstrb;
    load_last = s01_axis_tlast;
    if (state == ST_GRANT02) begin
      load_data = s02_axis_tdata;
      load_strb = s02_axis_tstrb;
      load_last = s02_axis_tlast;
    end
  end

  // Arbitration FSM: pick an owner in IDLE, release it on its accepted tlast.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state      <= ST_IDLE;
      grant      <= GRANT_NONE;
      last_owner <= OWNER_S02;
      pkt_cnt01  <= '0;
      pkt_cnt02  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s01_axis_tvalid && (!s02_axis_tvalid || last_owner == OWNER_S02)) begin
            state <= ST_GRANT01;
            grant <= GRANT_S01;
          end else if (s02_axis_tvalid) begin
            state <= ST_GRANT02;
            grant <= GRANT_S02;
          end
        end
        ST_GRANT01: begin
          if (acc01 && s01_axis_tlast) begin
            state      <= ST_IDLE;
            grant      <= GRANT_NONE;
            last_owner <= OWNER_S01;
            pkt_cnt01  <= pkt_cnt01 + CNT_ONE;
          end
        end
        ST_GRANT02: begin
          if (acc02 && s02_axis_tlast) begin
            state      <= ST_IDLE;
            grant      <= GRANT_NONE;
            last_owner <= OWNER_S02;
            pkt_cnt02  <= pkt_cnt02 + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

  axis_output_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (axis_aclk),
    .rst_n    (axis_aresetn),
    .in_valid (load_valid),
    .in_ready (slot_ready),
    .in_data  (load_data),
    .in_strb  (load_strb),
    .in_last  (load_last),
    .out_valid(m01_axis_tvalid),
    .out_ready(m01_axis_tready),
    .out_data (m01_axis_tdata),
    .out_strb (m01_axis_tstrb),
    .out_last (m01_axis_tlast)
  );

endmodule

// File: tb/tb_memory_stream_arbiter.sv
// Bench for memory_stream_arbiter: scoreboarded stream transfers, grant
// sequencing, back-pressure, mid-packet reset and counter wrap.
module tb_memory_stream_arbiter;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 16;
  localparam int EW = DW + SW + 1;

  // ---------------- clock / reset ----------------
  logic axis_aclk = 1'b0;
  logic axis_aresetn = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  logic [DW-1:0] s01_axis_tdata = '0;
  logic [SW-1:0] s01_axis_tstrb = '0;
  logic          s01_axis_tvalid = 1'b0;
  logic          s01_axis_tlast = 1'b0;
  logic          s01_axis_tready;
  logic [DW-1:0] s02_axis_tdata = '0;
  logic [SW-1:0] s02_axis_tstrb = '0;
  logic          s02_axis_tvalid = 1'b0;
  logic          s02_axis_tlast = 1'b0;
  logic          s02_axis_tready;
  logic [DW-1:0] m01_axis_tdata;
  logic [SW-1:0] m01_axis_tstrb;
  logic          m01_axis_tvalid;
  logic          m01_axis_tlast;
  logic          m01_axis_tready = 1'b0;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt01;
  logic [CW-1:0] pkt_cnt02;
  logic [1:0]    dbg_state;

  // narrow-counter instance shares all stimulus
  logic          w2_s01_tready, w2_s02_tready;
  logic [DW-1:0] w2_tdata;
  logic [SW-1:0] w2_tstrb;
  logic          w2_tvalid, w2_tlast;
  logic [1:0]    w2_grant, w2_state;
  logic [1:0]    w2_cnt01, w2_cnt02;

  memory_stream_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(s01_axis_tready),
    .s02_axis_tdata(s02_axis_tdata), .s02_axis_tstrb(s02_axis_tstrb),
    .s02_axis_tvalid(s02_axis_tvalid), .s02_axis_tlast(s02_axis_tlast),
    .s02_axis_tready(s02_axis_tready),
    .m01_axis_tdata(m01_axis_tdata), .m01_axis_tstrb(m01_axis_tstrb),
    .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tlast(m01_axis_tlast),
    .m01_axis_tready(m01_axis_tready),
    .grant(grant), .pkt_cnt01(pkt_cnt01), .pkt_cnt02(pkt_cnt02),
    .dbg_state(dbg_state)
  );

  memory_stream_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_w2 (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(w2_s01_tready),
    .s02_axis_tdata(s02_axis_tdata), .s02_axis_tstrb(s02_axis_tstrb),
    .s02_axis_tvalid(s02_axis_tvalid), .s02_axis_tlast(s02_axis_tlast),
    .s02_axis_tready(w2_s02_tready),
    .m01_axis_tdata(w2_tdata), .m01_axis_tstrb(w2_tstrb),
    .m01_axis_tvalid(w2_tvalid), .m01_axis_tlast(w2_tlast),
    .m01_axis_tready(m01_axis_tready),
    .grant(w2_grant), .pkt_cnt01(w2_cnt01), .pkt_cnt02(w2_cnt02),
    .dbg_state(w2_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_out = 0;
  int n_gap = 0;
  bit chk_lat = 1'b0;
  bit log_grant = 1'b0;
  bit gap_active = 1'b0;
  bit abort_drv = 1'b0;
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  logic [1:0]    grant_log[$];
  logic [1:0]    run_val[$];
  int            run_len[$];
  logic [EW-1:0] held = '0;
  bit            held_v = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge axis_aclk) cyc <= cyc + 1;

  // input side: every accepted beat becomes an expected output beat
  always @(negedge axis_aclk) begin
    if (axis_aresetn) begin
      if (s01_axis_tvalid && s01_axis_tready) begin
        exp_q.push_back({s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata});
        lat_q.push_back(cyc);
      end
      if (s02_axis_tvalid && s02_axis_tready) begin
        exp_q.push_back({s02_axis_tlast, s02_axis_tstrb, s02_axis_tdata});
        lat_q.push_back(cyc);
      end
      if (s01_axis_tready || s02_axis_tready)
        check_eq("ready_excl", 64'(s01_axis_tready & s02_axis_tready), 0);
    end
  end

  // output side: pop and compare, watch stall stability, log grant
  always @(negedge axis_aclk) begin
    if (axis_aresetn) begin
      if (held_v && m01_axis_tvalid)
        check_eq("hold_stable", {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata}, held);
      held_v <= m01_axis_tvalid && !m01_axis_tready;
      held   <= {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata};
      if (m01_axis_tvalid && m01_axis_tready) begin
        n_out = n_out + 1;
        check_eq("sb_nonempty", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [EW-1:0] e;
          int lc;
          e  = exp_q.pop_front();
          lc = lat_q.pop_front();
          check_eq("sb_beat", {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata}, e);
          if (chk_lat) check_eq("latency", cyc, lc + 1);
        end
      end
      if (log_grant) grant_log.push_back(grant);
      if (gap_active) begin
        n_gap = n_gap + 1;
        check_eq("gap_grant", grant, 2'b10);
        check_eq("gap_s01_ready", s01_axis_tready, 0);
      end
    end else begin
      held_v <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int req, input logic v, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic l);
    if (req == 1) begin
      s01_axis_tvalid = v; s01_axis_tdata = d; s01_axis_tstrb = s; s01_axis_tlast = l;
    end else begin
      s02_axis_tvalid = v; s02_axis_tdata = d; s02_axis_tstrb = s; s02_axis_tlast = l;
    end
  endtask

  // Sends one packet; optional valid gap of gap_len cycles after beat gap_at.
  task automatic send_pkt(input int req, input int n, input logic [DW-1:0] base,
                          input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      bit ok;
      int t;
      ok = 1'b0;
      t = 0;
      drive(req, 1'b1, base + DW'(i), SW'($urandom_range(0, 15)), i == n - 1);
      while (!ok && !abort_drv && t < 200) begin
        @(negedge axis_aclk);
        ok = (req == 1) ? s01_axis_tready : s02_axis_tready;
        t++;
      end
      if (abort_drv) begin
        drive(req, 1'b0, '0, '0, 1'b0);
        return;
      end
      check_eq("drv_accept", 64'(ok), 1);
      @(posedge axis_aclk); #1;
      if (i == n - 1) begin
        drive(req, 1'b0, '0, '0, 1'b0);
      end else if (i + 1 == gap_at) begin
        drive(req, 1'b0, '0, '0, 1'b0);
        gap_active = 1'b1;
        repeat (gap_len) @(posedge axis_aclk);
        #1;
        gap_active = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    axis_aresetn = 1'b0;
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0);
    m01_axis_tready = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #3 axis_aresetn = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge axis_aclk); #1;
  endtask

  task automatic compress_grant_log();
    run_val.delete();
    run_len.delete();
    foreach (grant_log[i]) begin
      int last;
      last = run_val.size() - 1;
      if (last >= 0 && run_val[last] == grant_log[i]) run_len[last] = run_len[last] + 1;
      else begin
        run_val.push_back(grant_log[i]);
        run_len.push_back(1);
      end
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge axis_aclk);
    #1;
  endtask

  // ---------------- tests ----------------
  initial begin
    int n0;
    logic [1:0] exp_gv[8];
    int exp_gl[8];
    int pat[6];
    logic [1:0] exp_w2[5];
    exp_gv = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_gl = '{1, 2, 1, 2, 1, 2, 1, 2};
    pat    = '{1, 0, 0, 1, 0, 1};
    exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // reset values
    #2;
    check_eq("rst_m_valid", m01_axis_tvalid, 0);
    check_eq("rst_m_data", {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata}, 0);
    check_eq("rst_ready", {s01_axis_tready, s02_axis_tready}, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_cnt", {pkt_cnt01, pkt_cnt02}, 0);
    check_eq("rst_state", dbg_state, 0);

    // 1: single requester, 3-beat packet
    apply_reset();
    chk_lat = 1'b1;
    n0 = n_out;
    send_pkt(1, 3, 32'hA1, 0, 0);
    drain();
    check_eq("t1_beats", n_out - n0, 3);
    check_eq("t1_cnt01", pkt_cnt01, 1);
    check_eq("t1_cnt02", pkt_cnt02, 0);
    check_eq("t1_grant", grant, 0);
    check_eq("t1_state", dbg_state, 0);

    // 2: both requesters contend continuously
    apply_reset();
    grant_log.delete();
    log_grant = 1'b1;
    fork
      begin send_pkt(1, 2, 32'h100, 0, 0); send_pkt(1, 2, 32'h110, 0, 0); end
      begin send_pkt(2, 2, 32'h200, 0, 0); send_pkt(2, 2, 32'h210, 0, 0); end
    join
    drain();
    log_grant = 1'b0;
    compress_grant_log();
    check_eq("t2_runs", run_val.size(), 9);
    for (int k = 0; k < 8; k++) begin
      check_eq("t2_owner", (k < run_val.size()) ? run_val[k] : 2'b11, exp_gv[k]);
      check_eq("t2_runlen", (k < run_len.size()) ? run_len[k] : -1, exp_gl[k]);
    end
    check_eq("t2_cnt01", pkt_cnt01, 2);
    check_eq("t2_cnt02", pkt_cnt02, 2);

    // 3: owner drops tvalid mid-packet while the other requests
    apply_reset();
    n_gap = 0;
    fork
      send_pkt(2, 3, 32'h300, 1, 3);
      begin repeat (2) @(posedge axis_aclk); #1; send_pkt(1, 1, 32'h400, 0, 0); end
    join
    drain();
    check_eq("t3_gap_cycles", n_gap, 3);
    check_eq("t3_cnt01", pkt_cnt01, 1);
    check_eq("t3_cnt02", pkt_cnt02, 1);

    // 4: downstream back-pressure pattern
    apply_reset();
    chk_lat = 1'b0;
    n0 = n_out;
    fork
      send_pkt(1, 4, 32'h10, 0, 0);
      begin
        for (int i = 0; i < 6; i++) begin
          m01_axis_tready = pat[i][0];
          @(posedge axis_aclk); #1;
        end
        m01_axis_tready = 1'b1;
      end
    join
    drain();
    check_eq("t4_beats", n_out - n0, 4);
    check_eq("t4_sb_empty", exp_q.size(), 0);
    check_eq("t4_cnt01", pkt_cnt01, 1);

    // 5: reset pulse during beat 2 of a packet
    chk_lat = 1'b1;
    fork
      send_pkt(1, 4, 32'h500, 0, 0);
      begin
        repeat (2) @(posedge axis_aclk);
        #3 axis_aresetn = 1'b0;
        abort_drv = 1'b1;
        #1;
        check_eq("t5_m_valid", m01_axis_tvalid, 0);
        check_eq("t5_m_data", {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata}, 0);
        check_eq("t5_grant", grant, 0);
        check_eq("t5_cnt", {pkt_cnt01, pkt_cnt02}, 0);
        check_eq("t5_ready", {s01_axis_tready, s02_axis_tready}, 0);
        check_eq("t5_state", dbg_state, 0);
        exp_q.delete();
        lat_q.delete();
        @(posedge axis_aclk);
        #3 axis_aresetn = 1'b1;
      end
    join
    abort_drv = 1'b0;
    @(posedge axis_aclk); #1;
    grant_log.delete();
    log_grant = 1'b1;
    fork
      send_pkt(1, 1, 32'h600, 0, 0);
      send_pkt(2, 1, 32'h700, 0, 0);
    join
    drain();
    log_grant = 1'b0;
    compress_grant_log();
    check_eq("t5_first_owner", (run_val.size() > 1) ? run_val[1] : 2'b11, 2'b01);
    check_eq("t5_cnt01", pkt_cnt01, 1);
    check_eq("t5_cnt02", pkt_cnt02, 1);

    // 6: narrow counter wrap with single-beat packets
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      send_pkt(2, 1, 32'h800 + DW'(k), 0, 0);
      check_eq("t6_w2_cnt02", w2_cnt02, exp_w2[k]);
      check_eq("t6_cnt02", pkt_cnt02, k + 1);
    end
    drain();
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_stream_arbiter.md
Name: memory_stream_arbiter

Overview:
Packet-granular, two-requester round-robin arbiter that shares the memory write stream (the AXI-Stream slave side of memory_wrapper) between two AXI-Stream producers. It selects one producer, forwards that producer's whole packet (up to and including tlast) through a registered output stage, then re-arbitrates. It also counts completed packets per requester for status and debug.

Parameters:
DATA_WIDTH, 32, width of tdata on all streams; tstrb width is DATA_WIDTH/8.
CNT_WIDTH, 16, width of each per-requester packet counter; wraps modulo 2^CNT_WIDTH.

Ports:
axis_aclk  in  1  single clock for all streams.
axis_aresetn  in  1  reset; asynchronous assert, active-low.
s01_axis_tdata  in  DATA_WIDTH  requester 1 data.
s01_axis_tstrb  in  DATA_WIDTH/8  requester 1 byte strobes.
s01_axis_tvalid  in  1  requester 1 valid.
s01_axis_tlast  in  1  requester 1 end of packet.
s01_axis_tready  out  1  requester 1 ready.
s02_axis_tdata / tstrb / tvalid / tlast / tready  same as s01_*, for requester 2.
m01_axis_tdata  out  DATA_WIDTH  data to memory_wrapper.
m01_axis_tstrb  out  DATA_WIDTH/8  strobes to memory_wrapper.
m01_axis_tvalid  out  1  output valid.
m01_axis_tlast  out  1  output end of packet.
m01_axis_tready  in  1  memory_wrapper ready.
grant  out  2  one-hot current owner (bit0 = s01, bit1 = s02); 00 when idle.
pkt_cnt01  out  CNT_WIDTH  completed packets forwarded from s01.
pkt_cnt02  out  CNT_WIDTH  completed packets forwarded from s02.

Behaviour:
- Clock and reset: one clock, axis_aclk. axis_aresetn is asynchronous, active-low.
- Reset values: all outputs are 0 (tready, m01_* signals, grant, counters). State = IDLE. last_owner = s02, so s01 has priority first.
- States: IDLE, GRANT01, GRANT02.
- IDLE:
  - Both s*_tready are 0.
  - If only one tvalid is high, go to that requester's GRANT state.
  - If both are high, grant the requester that is not last_owner.
  - If neither is high, stay in IDLE.
  - grant becomes one-hot on the same edge as the state change.
- GRANTxx:
  - Granted tready = (!m01_axis_tvalid || m01_axis_tready). Non-granted tready = 0.
  - Beat accepted when granted tvalid && tready.
  - Dropping tvalid mid-packet does not release the grant. Only a packet ends the grant.
  - On an accepted beat with tlast = 1: go to IDLE, set last_owner = this requester, increment this requester's pkt_cnt (wraps), and set grant to 00.
- Output register:
  - An accepted beat loads tdata, tstrb and tlast into the m01 register and sets m01_axis_tvalid on the next edge. Latency is 1 cycle.
  - m01_axis_tvalid clears when m01_axis_tready = 1 and no new beat loads in the same cycle.
  - Load and drain in the same cycle keeps tvalid = 1 with the new data, giving full throughput mid-packet.
  - m01 data is stable while tvalid = 1 and tready = 0.
- Per-packet overhead: exactly one IDLE cycle between packets (the arbitration bubble).
- Single-beat packet (tlast on the first beat): legal; counts as one packet.
- Back-pressure: m01_axis_tready held low stalls the granted requester with no data loss or duplication.
- Reset mid-packet: state, grant, output register and counters clear immediately. The downstream partial packet is abandoned; memory_wrapper is reset by the same signal.
- tstrb passes through unmodified. The arbiter does not interpret strobes.

Decomposition:
- Shared package/header memory_arbiter_defs:
  - state encodings ST_IDLE = 2'd0, ST_GRANT01 = 2'd1, ST_GRANT02 = 2'd2
  - GRANT_NONE = 2'b00
- Sub-module axis_output_register: one-entry AXI-Stream register slice (tdata, tstrb, tlast, tvalid/tready), parameterised on DATA_WIDTH.

Test Plan:
- Reset, then only s01 sends a 3-beat packet 0xA1, 0xA2, 0xA3 (tlast on 0xA3), with m01_axis_tready = 1 -> m01 emits the 3 beats in order, tlast on the third beat, pkt_cnt01 = 1, grant returns to 00.
- s01 and s02 both hold 2-beat packets continuously -> owners alternate s01, s02, s01, s02. After 4 packets pkt_cnt01 = 2 and pkt_cnt02 = 2, with one IDLE cycle between packets.
- s02 granted, its tvalid dropped for 3 cycles mid-packet while s01 asserts tvalid -> grant stays 10 (s02) and s01_axis_tready stays 0 until s02's tlast is accepted.
- m01_axis_tready toggles 1,0,0,1,0,1 during a 4-beat s01 packet 0x10..0x13 -> exactly 0x10..0x13 are output once each, and tdata is stable while stalled.
- axis_aresetn pulsed low for 1 cycle at a non-edge time during beat 2 of a packet -> all outputs and counters read 0 immediately; after release, s01 wins the first contention.
- With CNT_WIDTH = 2, s02 sends 5 single-beat packets -> pkt_cnt02 reads 1, 2, 3, 0, 1.
